// File: rtl/jtframe_prog_pkg.sv
// Shared types for the ROM download write buffer.
// Word bundle, byte-enable codes and a lane insert helper.
package jtframe_prog_pkg;

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  dsn;
  } prog_word_t;

  localparam logic [1:0] DSN_LO   = 2'b10;
  localparam logic [1:0] DSN_HI   = 2'b01;
  localparam logic [1:0] DSN_W    = 2'b00;
  localparam logic [1:0] DSN_NONE = 2'b11;

  // Writes byte b into every lane whose active-low enable is set.
  function automatic logic [15:0] put_byte(
    input logic [1:0]  mask,
    input logic [7:0]  b,
    input logic [15:0] old
  );
    put_byte = old;
    if (!mask[0]) put_byte[7:0]  = b;
    if (!mask[1]) put_byte[15:8] = b;
  endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Single-clock FIFO of prog_word_t entries.
// Ports: push/din in, pop/dout out, full, empty, free_slots.
module jtframe_prog_fifo
  import jtframe_prog_pkg::*;
#(
  parameter int DW_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  prog_word_t       din,
  input  logic             pop,
  output prog_word_t       dout,
  output logic             full,
  output logic             empty,
  output logic [DW_LOG2:0] free_slots
);

  localparam int DEPTH = 1 << DW_LOG2;
  localparam logic [DW_LOG2:0] DEPTH_V = (DW_LOG2+1)'(DEPTH);
  localparam logic [DW_LOG2:0] ONE = (DW_LOG2+1)'(1);

  prog_word_t       mem_q [DEPTH];
  prog_word_t       mem_d [DEPTH];
  logic [DW_LOG2:0] wr_q, wr_d;
  logic [DW_LOG2:0] rd_q, rd_d;
  logic [DW_LOG2:0] used;
  logic             push_ok;
  logic             pop_ok;

  assign empty = wr_q == rd_q;
  assign full  = (wr_q[DW_LOG2] != rd_q[DW_LOG2]) &&
                 (wr_q[DW_LOG2-1:0] == rd_q[DW_LOG2-1:0]);
  assign used       = wr_q - rd_q;
  assign free_slots = DEPTH_V - used;
  assign dout       = mem_q[rd_q[DW_LOG2-1:0]];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q[DW_LOG2-1:0]] = din;
      wr_d = wr_q + ONE;
    end
    if (pop_ok) rd_d = rd_q + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/jtframe_prog_wrbuf.sv
// Merges prog_* byte writes into 16-bit words and queues them to SDRAM.
// In: prog_* byte stream, downloading, ba_rdy. Out: sdram_ack, ba_*, done.
module jtframe_prog_wrbuf
  import jtframe_prog_pkg::*;
#(
  parameter int DW_LOG2      = 2,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_we,
  output logic        sdram_ack,
  output logic [21:0] ba_addr,
  output logic [15:0] ba_din,
  output logic [1:0]  ba_dsn,
  output logic        ba_wr,
  input  logic        ba_rdy,
  output logic        done
);

  typedef enum logic {ST_IDLE, ST_WAIT} st_t;

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(FLUSH_CYCLES - 1);
  localparam int AW = DW_LOG2 + 2;

  st_t              st_q, st_d;
  prog_word_t       ba_q, ba_d;
  logic             ba_wr_q, ba_wr_d;
  prog_word_t       m_q, m_d;
  logic             m_vld_q, m_vld_d;
  logic [CW-1:0]    idle_q, idle_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;

  logic             push;
  logic             pop;
  prog_word_t       push_word;
  prog_word_t       head;
  logic             full;
  logic             empty;
  logic [DW_LOG2:0] free_slots;
  logic [AW-1:0]    avail;

  prog_word_t       new_w;
  logic             same_word;
  logic             can_go;
  logic             accept;
  logic             flush;

  jtframe_prog_fifo #(.DW_LOG2(DW_LOG2)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .din        (push_word),
    .pop        (pop),
    .dout       (head),
    .full       (full),
    .empty      (empty),
    .free_slots (free_slots)
  );

  assign sdram_ack = ack_q;
  assign ba_addr   = ba_q.addr;
  assign ba_din    = ba_q.data;
  assign ba_dsn    = ba_q.dsn;
  assign ba_wr     = ba_wr_q;
  assign done      = done_q;

  always_comb begin
    st_d    = st_q;
    ba_d    = ba_q;
    ba_wr_d = ba_wr_q;
    pop     = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (!empty) begin
          ba_d    = head;
          ba_wr_d = 1'b1;
          pop     = 1'b1;
          st_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ba_rdy) begin
          ba_wr_d = 1'b0;
          st_d    = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Slots usable this cycle, counting the one a concurrent pop frees.
  assign avail = AW'(free_slots) + AW'(pop);

  always_comb begin
    m_d       = m_q;
    m_vld_d   = m_vld_q;
    idle_d    = idle_q;
    push      = 1'b0;
    push_word = m_q;
    flush     = 1'b0;

    new_w.addr = prog_addr;
    new_w.dsn  = prog_mask;
    new_w.data = put_byte(prog_mask, prog_data, 16'h0);

    same_word = m_vld_q && (m_q.addr == prog_addr) &&
                ((m_q.dsn | prog_mask) == DSN_NONE) &&
                ((m_q.dsn & prog_mask) == DSN_W);

    // A full word parks in M for one cycle; reserving two slots
    // guarantees both it and any older half word get a slot.
    if (prog_mask == DSN_NONE)   can_go = 1'b1;
    else if (prog_mask == DSN_W) can_go = avail >= AW'(2);
    else if (!m_vld_q)           can_go = 1'b1;
    else                         can_go = !full || pop;

    accept = prog_we && !ack_q && downloading && can_go;

    if (accept) begin
      idle_d = '0;
      if (prog_mask == DSN_NONE) begin
        m_vld_d = m_vld_q;
      end else if (same_word) begin
        push           = 1'b1;
        push_word.data = put_byte(prog_mask, prog_data, m_q.data);
        push_word.dsn  = DSN_W;
        m_vld_d        = 1'b0;
      end else begin
        push    = m_vld_q;
        m_d     = new_w;
        m_vld_d = 1'b1;
      end
    end else if (m_vld_q) begin
      flush = (m_q.dsn == DSN_W) ||
              ((!downloading || idle_q == IDLE_LAST) && avail != '0);
      if (flush) begin
        push    = 1'b1;
        m_vld_d = 1'b0;
        idle_d  = '0;
      end else if (idle_q != IDLE_LAST) begin
        idle_d = idle_q + CW'(1);
      end
    end else begin
      idle_d = '0;
    end

    ack_d  = accept;
    done_d = !downloading && !m_vld_q && empty && (st_q == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      ba_q    <= '{addr: '0, data: '0, dsn: DSN_NONE};
      ba_wr_q <= 1'b0;
      m_q     <= '{addr: '0, data: '0, dsn: DSN_NONE};
      m_vld_q <= 1'b0;
      idle_q  <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      ba_q    <= ba_d;
      ba_wr_q <= ba_wr_d;
      m_q     <= m_d;
      m_vld_q <= m_vld_d;
      idle_q  <= idle_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_jtframe_prog_wrbuf.sv
// Directed bench for jtframe_prog_wrbuf.
// Byte-pair table plus flush, stall and reset sequences.
module tb_jtframe_prog_wrbuf;
  import jtframe_prog_pkg::*;

  localparam int FLUSH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [21:0] prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [1:0]  prog_mask = 2'b11;
  logic        prog_we = 1'b0;
  logic        sdram_ack;
  logic [21:0] ba_addr;
  logic [15:0] ba_din;
  logic [1:0]  ba_dsn;
  logic        ba_wr;
  logic        ba_rdy = 1'b0;
  logic        done;

  always #5 clk = ~clk;

  jtframe_prog_wrbuf #(.DW_LOG2(2), .FLUSH_CYCLES(FLUSH)) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .sdram_ack   (sdram_ack),
    .ba_addr     (ba_addr),
    .ba_din      (ba_din),
    .ba_dsn      (ba_dsn),
    .ba_wr       (ba_wr),
    .ba_rdy      (ba_rdy),
    .done        (done)
  );

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] din;
    logic [1:0]  dsn;
  } wr_t;

  typedef struct {
    logic [21:0] a1;
    logic [1:0]  m1;
    logic [7:0]  d1;
    logic [21:0] a2;
    logic [1:0]  m2;
    logic [7:0]  d2;
    int          nw;
    wr_t         w0;
    wr_t         w1;
  } vec_t;

  wr_t wlog[$];
  int  ack_total = 0;
  int  ack_dbl = 0;
  int  stab_err = 0;
  bit  rdy_en = 1'b0;
  int  chk_n = 0;
  int  pass_n = 0;

  // SDRAM model and bus monitor
  initial begin : sdram
    logic prev_ack;
    logic prev_wr;
    wr_t  prev;
    wr_t  cur;
    prev_ack = 1'b0;
    prev_wr  = 1'b0;
    prev     = '0;
    forever begin
      @(negedge clk);
      cur = {ba_addr, ba_din, ba_dsn};
      if (sdram_ack) ack_total++;
      if (sdram_ack && prev_ack) ack_dbl++;
      if (ba_wr && prev_wr && cur != prev) stab_err++;
      prev_ack = sdram_ack;
      prev_wr  = ba_wr;
      prev     = cur;
      if (ba_rdy) ba_rdy = 1'b0;
      else if (ba_wr && rdy_en) begin
        ba_rdy = 1'b1;
        wlog.push_back(cur);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    chk_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [21:0] a, input logic [1:0] m,
                      input logic [7:0] d);
    bit got;
    got = 1'b0;
    prog_addr = a;
    prog_mask = m;
    prog_data = d;
    prog_we   = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (sdram_ack) got = 1'b1;
    end
    prog_we = 1'b0;
    if (!got) chk("ack_timeout", 32'(sdram_ack), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  task automatic check_wr(input string nm, input wr_t got, input wr_t exp);
    logic [15:0] lm;
    lm = {{8{~exp.dsn[1]}}, {8{~exp.dsn[0]}}};
    chk({nm, "_addr"}, 32'(got.addr), 32'(exp.addr));
    chk({nm, "_dsn"}, 32'(got.dsn), 32'(exp.dsn));
    chk({nm, "_din"}, 32'(got.din & lm), 32'(exp.din & lm));
  endtask

  vec_t vt[6];

  initial begin : main
    int base;
    int a0;
    int lat;
    int hi;
    wr_t nul;
    nul = {22'h0, 16'h0, 2'b11};

    vt[0] = '{22'h10, 2'b10, 8'h34, 22'h10, 2'b01, 8'h12, 1,
              {22'h10, 16'h1234, 2'b00}, nul};
    vt[1] = '{22'h30, 2'b10, 8'h55, 22'h31, 2'b10, 8'h66, 2,
              {22'h30, 16'h0055, 2'b10}, {22'h31, 16'h0066, 2'b10}};
    vt[2] = '{22'h50, 2'b00, 8'h7E, 22'h51, 2'b11, 8'h99, 1,
              {22'h50, 16'h7E7E, 2'b00}, nul};
    vt[3] = '{22'h60, 2'b01, 8'hBB, 22'h60, 2'b01, 8'hCC, 2,
              {22'h60, 16'hBB00, 2'b01}, {22'h60, 16'hCC00, 2'b01}};
    vt[4] = '{22'h70, 2'b01, 8'h9A, 22'h70, 2'b10, 8'hBC, 1,
              {22'h70, 16'h9ABC, 2'b00}, nul};
    vt[5] = '{22'h80, 2'b10, 8'h11, 22'h81, 2'b00, 8'h22, 2,
              {22'h80, 16'h0011, 2'b10}, {22'h81, 16'h2222, 2'b00}};

    cycles(2);
    chk("rst_ack", 32'(sdram_ack), 32'd0);
    chk("rst_wr", 32'(ba_wr), 32'd0);
    chk("rst_dsn", 32'(ba_dsn), 32'd3);
    chk("rst_addr", 32'(ba_addr), 32'd0);
    chk("rst_din", 32'(ba_din), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    cycles(2);

    foreach (vt[i]) begin
      downloading = 1'b1;
      rdy_en = 1'b1;
      base = wlog.size();
      a0 = ack_total;
      cycles(2);
      send(vt[i].a1, vt[i].m1, vt[i].d1);
      send(vt[i].a2, vt[i].m2, vt[i].d2);
      downloading = 1'b0;
      wait_done($sformatf("v%0d_done", i));
      chk($sformatf("v%0d_acks", i), ack_total - a0, 32'd2);
      chk($sformatf("v%0d_nwr", i), wlog.size() - base, vt[i].nw);
      for (int j = 0; j < vt[i].nw && base + j < wlog.size(); j++)
        check_wr($sformatf("v%0d_w%0d", i, j), wlog[base + j],
                 (j == 0) ? vt[i].w0 : vt[i].w1);
    end

    // idle flush of a lone half word
    downloading = 1'b1;
    rdy_en = 1'b1;
    base = wlog.size();
    cycles(2);
    send(22'h20, 2'b10, 8'hAA);
    lat = 0;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(negedge clk);
      if (ba_wr) lat = k;
    end
    chk("flush_latency", lat, FLUSH + 1);
    cycles(3);
    chk("flush_nwr", wlog.size() - base, 32'd1);
    if (wlog.size() > base)
      check_wr("flush_w", wlog[base], {22'h20, 16'h00AA, 2'b10});
    downloading = 1'b0;
    wait_done("flush_done");

    // stalled SDRAM while 12 bytes stream
    downloading = 1'b1;
    rdy_en = 1'b0;
    base = wlog.size();
    a0 = ack_total;
    cycles(2);
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(22'(256 + i), 2'b10, 8'(i * 3 + 1));
      end
      begin
        cycles(40);
        chk("stall_acks", ack_total - a0, 32'd6);
        chk("stall_wr", 32'(ba_wr), 32'd1);
        chk("stall_nwr", wlog.size() - base, 32'd0);
        rdy_en = 1'b1;
      end
    join
    downloading = 1'b0;
    wait_done("stall_done");
    chk("stall_total_acks", ack_total - a0, 32'd12);
    chk("stall_total_nwr", wlog.size() - base, 32'd12);
    for (int i = 0; i < 12 && base + i < wlog.size(); i++)
      check_wr($sformatf("stall_w%0d", i), wlog[base + i],
               {22'(256 + i), 8'h00, 8'(i * 3 + 1), 2'b10});

    // async reset with a write in flight and 3 queued words
    downloading = 1'b1;
    rdy_en = 1'b0;
    cycles(2);
    for (int i = 0; i < 5; i++)
      send(22'(512 + i), 2'b10, 8'(64 + i));
    cycles(3);
    chk("pre_rst_wr", 32'(ba_wr), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_wr", 32'(ba_wr), 32'd0);
    chk("arst_dsn", 32'(ba_dsn), 32'd3);
    chk("arst_addr", 32'(ba_addr), 32'd0);
    chk("arst_din", 32'(ba_din), 32'd0);
    chk("arst_ack", 32'(sdram_ack), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rdy_en = 1'b1;
    base = wlog.size();
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (ba_wr) hi++;
    end
    chk("post_rst_nowr", hi, 32'd0);
    chk("post_rst_nlog", wlog.size() - base, 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    downloading = 1'b0;
    cycles(2);
    chk("post_rst_done1", 32'(done), 32'd1);

    chk("ack_width", ack_dbl, 32'd0);
    chk("ba_stable", stab_err, 32'd0);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule

// File: doc/jtframe_prog_wrbuf.md
Name: jtframe_prog_wrbuf

Overview:
- Downstream consumer of the ROM download stage's prog_* byte stream.
- Accepts byte writes (22-bit word address, 8-bit data, active-low 2-bit mask) and returns a one-cycle sdram_ack per accepted byte.
- Merges complementary byte pairs to the same word into single 16-bit writes.
- Queues the words in a small FIFO and drains them to the SDRAM controller's write bank port with a req/rdy handshake. Decouples ioctl byte rate from SDRAM refresh/arbitration stalls.

Parameters:
- DW_LOG2, 2, log2 of FIFO depth (depth 4 by default).
- FLUSH_CYCLES, 16, idle cycles after which a half-filled merge register is pushed alone.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- downloading  in  1  download in progress
- prog_addr  in  22  word address
- prog_data  in  8  byte data
- prog_mask  in  2  active-low byte enables: bit0 low = din[7:0], bit1 low = din[15:8]
- prog_we  in  1  write request, held until sdram_ack
- sdram_ack  out  1  one-cycle acceptance pulse back to download stage
- ba_addr  out  22  SDRAM word address
- ba_din  out  16  SDRAM write data
- ba_dsn  out  2  active-low byte enables to SDRAM
- ba_wr  out  1  write request, held until ba_rdy
- ba_rdy  in  1  one-cycle: SDRAM write committed
- done  out  1  download finished and all data written

Behaviour:
- Reset (async, rst=1): all outputs 0 except ba_dsn=2'b11. FIFO empty. Merge register invalid. Idle counter 0.
- Accept condition: prog_we && !sdram_ack && downloading && merge path able to proceed.
  - sdram_ack is registered, high exactly one cycle after the accepting edge.
  - The !sdram_ack term prevents double acceptance while the upstream prog_we falls.
- Merge register (M: addr, data16, dsn, valid) on an accepted byte:
  - M invalid: load byte into the lane selected by mask; dsn=mask; valid=1. No push.
  - M valid, same addr, (M.dsn | mask)==2'b11 and (M.dsn & mask)==2'b00: merged word {dsn=2'b00} pushed to FIFO; M invalid. Needs 1 free FIFO slot.
  - M valid otherwise (different addr or same lane): push M as-is; load new byte into M. Needs 1 free slot.
  - Mask 2'b00 (both lanes): prog_data is replicated to both lanes; handled as a complete word (flush M first if valid). This takes 2 consecutive cycles and is accepted only when 2 slots are free.
  - Mask 2'b11: accepted and acked, no write.
- Full FIFO: acceptance stalls, no ack, and prog_we stays high upstream. No data loss.
- Idle flush: counter increments while M valid and no acceptance. At FLUSH_CYCLES-1 it pushes M (if a slot is free) and clears. Any acceptance resets the counter.
- Falling downloading: M pushed on the next cycle a slot is free. Bytes offered while downloading=0 are ignored (no ack).
- FIFO: DW_LOG2-bit pointers plus wrap bit. full/empty come from the pointer compare. Simultaneous push and pop is allowed when full, because the pop frees a slot in the same cycle.
- Drain FSM:
  - IDLE: if FIFO not empty, latch head into ba_addr/ba_din/ba_dsn, set ba_wr=1, pop, go to WAIT.
  - WAIT: hold all ba_* stable. On ba_rdy clear ba_wr; go to IDLE (or straight to the next entry next cycle).
  - Issue-to-issue minimum is 2 cycles.
- done=1 when downloading=0, M invalid, FIFO empty and drain in IDLE. Registered.
- Reset mid-transfer: immediate return to reset state. The in-flight SDRAM write is abandoned (controller is reset alongside).

Decomposition:
- Shared package jtframe_prog_pkg holds:
  - typedef prog_word_t {addr[21:0], data[15:0], dsn[1:0]}
  - constants DSN_LO=2'b10, DSN_HI=2'b01, DSN_W=2'b00, DSN_NONE=2'b11
- Sub-module jtframe_prog_fifo: synchronous single-clock FIFO of prog_word_t with push/pop/full/empty/free_slots.

Test Plan:
- Bytes addr 0x10 mask 10 data 0x34, then addr 0x10 mask 01 data 0x12 -> exactly one ba_wr with addr 0x10, din 0x1234, dsn 00. sdram_ack pulses twice, each 1 cycle wide.
- Byte addr 0x20 mask 10 data 0xAA, then no traffic -> after FLUSH_CYCLES, ba_wr with din lane0=0xAA, dsn 10.
- ba_rdy held low while 12 bytes stream -> acks stop once FIFO is full and M is occupied. Releasing ba_rdy drains all words in order with no loss or duplication.
- Bytes to addr 0x30 lane0 then addr 0x31 lane0 -> two partial writes, dsn 10 each, in that order.
- Half word in M, downloading falls -> M written, then done=1 after its ba_rdy.
- rst asserted with ba_wr high and FIFO holding 3 entries -> all outputs return to reset values asynchronously. Post-reset, FIFO is empty and done=0 until downloading=0.
